// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
//   Shared types and constants for the multiplexed seven-segment display
//   path. Segment codes are active-low; bit 0 is segment a and bit 6 is
//   segment g.
// ---------------------------------------------------------------------------
package clock_pkg;

  typedef logic [6:0] seg_t;

  // Active-low patterns for the decimal digits.
  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;

  // Only segment g lit: shown for BCD values 10..15.
  localparam seg_t SEG_DASH  = 7'h3F;

  // Every segment dark: guard cycles, blink-off slots and reset.
  localparam seg_t SEG_BLANK = 7'h7F;

  // Blink phase. The display starts in the on phase.
  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_ph_t;

endpackage

// File: rtl/bcd_to_seg.sv
// ---------------------------------------------------------------------------
// bcd_to_seg
//   Purely combinational BCD to active-low seven-segment decoder.
//   Ports:
//     bcd_i  in   4  BCD digit (10..15 are treated as invalid)
//     seg_o  out  7  active-low segments a..g in bits 0..6
// ---------------------------------------------------------------------------
module bcd_to_seg
  import clock_pkg::*;
(
  input  logic [3:0] bcd_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
//   Time-multiplexed driver for an N_DIGITS common-anode seven-segment
//   display. Each digit owns a slot of SCAN_DIV clocks. The first GUARD
//   clocks of every slot keep all anodes off so the previous digit's
//   segments never ghost onto the next anode.
//
//   New content is staged in a pending register on `load` and copied into
//   the display register only when the slot index wraps, so a frame is
//   always drawn from one consistent snapshot.
//
//   Ports:
//     clk         in   1            system clock
//     reset       in   1            asynchronous, active-high reset
//     digits_in   in   4*N_DIGITS   packed BCD, digit 0 in bits [3:0]
//     load        in   1            strobe: capture digits/blink/dp masks
//     blink_mask  in   N_DIGITS     digit blanks during the blink-off phase
//     dp_mask     in   N_DIGITS     decimal point lit for the digit
//     seg_n       out  7            segments a..g, active-low
//     dp_n        out  1            decimal point, active-low
//     an_n        out  N_DIGITS     anodes, active-low, at most one low
//     frame_done  out  1            one-cycle pulse as the index wraps to 0
//
//   All outputs are registered and lag the prescaler/index by one cycle.
// ---------------------------------------------------------------------------
module seven_seg_scanner
  import clock_pkg::*;
#(
  parameter int N_DIGITS     = 6,
  parameter int SCAN_DIV     = 100,
  parameter int GUARD        = 4,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic [N_DIGITS-1:0]   dp_mask,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIGITS);
  // +1 keeps the counter at least one bit wide when BLINK_FRAMES is 1.
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRESC_GUARD = PW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST    = IW'(N_DIGITS - 1);
  localparam logic [FW-1:0] FCNT_LAST   = FW'(BLINK_FRAMES - 1);

  // ---- scan timing ----
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  blink_ph_t     blink_q, blink_d;

  // ---- staged and displayed content ----
  logic [N_DIGITS-1:0][3:0] pend_dig_q, pend_dig_d;
  logic [N_DIGITS-1:0]      pend_blink_q, pend_blink_d;
  logic [N_DIGITS-1:0]      pend_dp_q, pend_dp_d;
  logic                     pend_vld_q, pend_vld_d;

  logic [N_DIGITS-1:0][3:0] disp_dig_q, disp_dig_d;
  logic [N_DIGITS-1:0]      disp_blink_q, disp_blink_d;
  logic [N_DIGITS-1:0]      disp_dp_q, disp_dp_d;

  // ---- output registers ----
  seg_t                seg_n_q, seg_n_d;
  logic                dp_n_q, dp_n_d;
  logic [N_DIGITS-1:0] an_n_q, an_n_d;
  logic                frame_done_q, frame_done_d;

  logic slot_end;
  logic frame_wrap;
  logic [3:0] cur_bcd;
  seg_t cur_seg;
  logic lit;
  logic dark;

  assign slot_end   = (presc_q == PRESC_LAST);
  assign frame_wrap = slot_end && (idx_q == IDX_LAST);

  // ---- prescaler, slot index and blink phase ----
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (slot_end) begin
      presc_d = '0;
      idx_d   = frame_wrap ? '0 : idx_q + 1'b1;
    end
    if (frame_wrap) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        blink_d = (blink_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // ---- pending / display registers ----
  // A load on the wrap cycle bypasses pending and lands straight in the
  // display register, so it takes effect at this boundary, not the next.
  always_comb begin
    pend_dig_d   = pend_dig_q;
    pend_blink_d = pend_blink_q;
    pend_dp_d    = pend_dp_q;
    pend_vld_d   = pend_vld_q;
    disp_dig_d   = disp_dig_q;
    disp_blink_d = disp_blink_q;
    disp_dp_d    = disp_dp_q;

    if (load) begin
      pend_dig_d   = digits_in;
      pend_blink_d = blink_mask;
      pend_dp_d    = dp_mask;
      pend_vld_d   = 1'b1;
    end

    if (frame_wrap) begin
      pend_vld_d = 1'b0;
      if (load) begin
        disp_dig_d   = digits_in;
        disp_blink_d = blink_mask;
        disp_dp_d    = dp_mask;
      end else if (pend_vld_q) begin
        disp_dig_d   = pend_dig_q;
        disp_blink_d = pend_blink_q;
        disp_dp_d    = pend_dp_q;
      end
    end
  end

  // ---- segment decode for the digit in the current slot ----
  assign cur_bcd = disp_dig_q[idx_q];

  bcd_to_seg u_bcd_to_seg (
    .bcd_i (cur_bcd),
    .seg_o (cur_seg)
  );

  assign lit  = (presc_q >= PRESC_GUARD);
  // Blink-off keeps the slot's timing; only the anode and segments go dark.
  assign dark = disp_blink_q[idx_q] && (blink_q == BLINK_OFF);

  always_comb begin
    seg_n_d      = SEG_BLANK;
    dp_n_d       = 1'b1;
    an_n_d       = '1;
    frame_done_d = frame_wrap;
    if (lit && !dark) begin
      an_n_d[idx_q] = 1'b0;
      seg_n_d       = cur_seg;
      dp_n_d        = ~disp_dp_q[idx_q];
    end
  end

  // ---- state ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      fcnt_q       <= '0;
      blink_q      <= BLINK_ON;
      pend_dig_q   <= '0;
      pend_blink_q <= '0;
      pend_dp_q    <= '0;
      pend_vld_q   <= 1'b0;
      disp_dig_q   <= '0;
      disp_blink_q <= '0;
      disp_dp_q    <= '0;
      seg_n_q      <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      fcnt_q       <= fcnt_d;
      blink_q      <= blink_d;
      pend_dig_q   <= pend_dig_d;
      pend_blink_q <= pend_blink_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      disp_dig_q   <= disp_dig_d;
      disp_blink_q <= disp_blink_d;
      disp_dp_q    <= disp_dp_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule
